// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Holds the stream word width, the arbiter state encoding and the modular index increment.
package bus_arbiter_rr_pkg;

    localparam int BUS_WORD_W = 64;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Next requester index after idx, wrapping n-1 -> 0 (works for non power-of-two n).
    function automatic int idx_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning ptr, ptr+1, ... mod NREQ.
// Returns whether anything was found, its index and the matching one-hot vector.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            any,
    output logic [IDXW-1:0] idx,
    output logic [NREQ-1:0] onehot
);

    logic [IDXW-1:0] rot_idx [NREQ];
    logic [NREQ-1:0] rot_req;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            // Position gi of the rotated view is requester (ptr + gi) mod NREQ.
            assign rot_idx[gi] = IDXW'((32'(ptr) + gi) % NREQ);
            assign rot_req[gi] = req[rot_idx[gi]];
            assign onehot[gi]  = any && (idx == IDXW'(gi));
        end
    endgenerate

    // Scan from the far end so the lowest rotated position wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                any = 1'b1;
                idx = rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin burst arbiter routing one requester's 64-bit words to a shared sink.
// Define BUS_ARB_BACK2BACK_EN to re-arbitrate during the last transfer (no idle cycle between bursts).
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int N    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_start,
    input  logic [NREQ*N-1:0]          req_numSteps,
    output logic [NREQ-1:0]            req_grant,
    input  logic [NREQ*BUS_WORD_W-1:0] req_data,
    input  logic [NREQ-1:0]            req_isReady,
    output logic [NREQ-1:0]            req_canReceive,
    output logic [BUS_WORD_W-1:0]      out_data,
    output logic                       out_isReady,
    input  logic                       out_canReceive,
    output logic                       out_isLast,
    output logic [$clog2(NREQ)-1:0]    out_grantId,
    output logic                       busy
);

    localparam int IDXW = $clog2(NREQ);

    arb_state_e      state_reg, state_next;
    logic [IDXW-1:0] owner_reg, owner_next;
    logic [IDXW-1:0] ptr_reg, ptr_next;
    logic [N-1:0]    cnt_reg, cnt_next;

    logic [BUS_WORD_W-1:0] data_arr  [NREQ];
    logic [N-1:0]          steps_arr [NREQ];

    logic            pick_any;
    logic [IDXW-1:0] pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic            xfer;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign data_arr[gi]  = req_data[gi*BUS_WORD_W +: BUS_WORD_W];
            assign steps_arr[gi] = req_numSteps[gi*N +: N];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req    (req_start),
        .ptr    (ptr_reg),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

`ifdef BUS_ARB_BACK2BACK_EN
    logic [NREQ-1:0] owner_onehot;
    logic [IDXW-1:0] owner_inc;
    logic            b2b_any;
    logic [IDXW-1:0] b2b_idx;
    logic [NREQ-1:0] b2b_onehot;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_owner_oh
            assign owner_onehot[gi] = (owner_reg == IDXW'(gi));
        end
    endgenerate

    assign owner_inc = IDXW'(idx_inc(32'(owner_reg), NREQ));

    // The finishing owner is masked out so it cannot immediately win again.
    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick_b2b (
        .req    (req_start & ~owner_onehot),
        .ptr    (owner_inc),
        .any    (b2b_any),
        .idx    (b2b_idx),
        .onehot (b2b_onehot)
    );
`endif

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        cnt_next       = cnt_reg;
        ptr_next       = ptr_reg;
        req_grant      = '0;
        req_canReceive = '0;
        out_data       = '0;
        out_isReady    = 1'b0;
        out_isLast     = 1'b0;
        xfer           = 1'b0;

        case (state_reg)
            ARB_IDLE: begin
                if (pick_any) begin
                    req_grant = pick_onehot;
                    if (steps_arr[pick_idx] != '0) begin
                        owner_next = pick_idx;
                        cnt_next   = steps_arr[pick_idx];
                        state_next = ARB_BURST;
                    end else begin
                        // Zero-length burst: consume the grant and move the pointer past it.
                        ptr_next = IDXW'(idx_inc(32'(pick_idx), NREQ));
                    end
                end
            end

            ARB_BURST: begin
                out_data                  = data_arr[owner_reg];
                out_isReady               = req_isReady[owner_reg] && (cnt_reg != '0);
                req_canReceive[owner_reg] = out_canReceive;
                out_isLast                = out_isReady && (cnt_reg == N'(1));
                xfer                      = out_isReady && out_canReceive;

                if (xfer) begin
                    cnt_next = cnt_reg - N'(1);
                    if (cnt_reg == N'(1)) begin
                        ptr_next   = IDXW'(idx_inc(32'(owner_reg), NREQ));
                        state_next = ARB_IDLE;
`ifdef BUS_ARB_BACK2BACK_EN
                        if (b2b_any) begin
                            req_grant = b2b_onehot;
                            if (steps_arr[b2b_idx] != '0) begin
                                owner_next = b2b_idx;
                                cnt_next   = steps_arr[b2b_idx];
                                state_next = ARB_BURST;
                            end else begin
                                ptr_next = IDXW'(idx_inc(32'(b2b_idx), NREQ));
                            end
                        end
`endif
                    end
                end
            end

            default: begin
                state_next = ARB_IDLE;
            end
        endcase

        // No grant may escape while reset is held, even though the picker is combinational.
        if (!rst) begin
            req_grant = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ARB_IDLE;
            owner_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign busy        = (state_reg == ARB_BURST);
    assign out_grantId = owner_reg;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: directed bursts push expected grants and words,
// a negedge monitor pops and compares whenever the DUT grants or completes a transfer.
module tb_bus_arbiter_rr;

    localparam int NREQ = 4;
    localparam int N    = 8;
    localparam int W    = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_start;
    logic [NREQ*N-1:0]    req_numSteps;
    logic [NREQ-1:0]      req_grant;
    logic [NREQ*W-1:0]    req_data;
    logic [NREQ-1:0]      req_isReady;
    logic [NREQ-1:0]      req_canReceive;
    logic [W-1:0]         out_data;
    logic                 out_isReady;
    logic                 out_canReceive;
    logic                 out_isLast;
    logic [1:0]           out_grantId;
    logic                 busy;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .NREQ (NREQ),
        .N    (N)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_start      (req_start),
        .req_numSteps   (req_numSteps),
        .req_grant      (req_grant),
        .req_data       (req_data),
        .req_isReady    (req_isReady),
        .req_canReceive (req_canReceive),
        .out_data       (out_data),
        .out_isReady    (out_isReady),
        .out_canReceive (out_canReceive),
        .out_isLast     (out_isLast),
        .out_grantId    (out_grantId),
        .busy           (busy)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic [1:0]   id;
    } word_t;

    int    exp_grant [$];
    word_t exp_word  [$];
    int    xfer_cyc  [$];

    int n_cmp = 0;
    int n_err = 0;
    int n_grants = 0;
    int cyc = 0;

    logic [NREQ-1:0] granted_mask = '0;
    logic [NREQ-1:0] accept_mask  = '0;

    // Per-requester word sources
    logic [W-1:0] src_mem [NREQ][16];
    int           src_rd  [NREQ];
    int           src_cnt [NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NREQ; i++) begin
            if (src_rd[i] < src_cnt[i]) begin
                req_isReady[i]      = 1'b1;
                req_data[i*W +: W]  = src_mem[i][src_rd[i]];
            end else begin
                req_isReady[i]      = 1'b0;
                req_data[i*W +: W]  = '0;
            end
        end
    endtask

    task automatic load(input int i, input logic [W-1:0] w);
        src_mem[i][src_cnt[i]] = w;
        src_cnt[i]++;
        refresh();
    endtask

    task automatic set_steps(input int i, input int s);
        req_numSteps[i*N +: N] = N'(s);
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic last, input int id);
        word_t w;
        w.data = d;
        w.last = last;
        w.id   = 2'(id);
        exp_word.push_back(w);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        while (n_grants < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (n_grants < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", n_grants, n);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while ((exp_grant.size() != 0 || exp_word.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_grant.size() != 0 || exp_word.size() != 0 || busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: pending grants %0d words %0d busy %0b expected none",
                     name, exp_grant.size(), exp_word.size(), busy);
            exp_grant.delete();
            exp_word.delete();
        end
        step();
    endtask

    // Requester model: drop req_start after a grant, advance sources after accepted words.
    always @(posedge clk) begin
        #1;
        cyc++;
        req_start    = req_start & ~granted_mask;
        granted_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (accept_mask[i]) src_rd[i]++;
        end
        accept_mask = '0;
        refresh();
    end

    // Monitor / scoreboard
    int    mon_g;
    word_t mon_w;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (req_grant != '0) begin
                n_grants++;
                granted_mask = granted_mask | req_grant;
                if (exp_grant.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_grant: got 0x%0h expected none", req_grant);
                end else begin
                    mon_g = exp_grant.pop_front();
                    check("grant", 64'(req_grant), 64'(1) << mon_g);
                end
            end
            if (out_isReady && out_canReceive) begin
                accept_mask = accept_mask | (req_canReceive & req_isReady);
                xfer_cyc.push_back(cyc);
                if (exp_word.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_xfer: got 0x%0h expected none", out_data);
                end else begin
                    mon_w = exp_word.pop_front();
                    check("xfer_data", out_data, mon_w.data);
                    check("xfer_last", 64'(out_isLast), 64'(mon_w.last));
                    check("xfer_id", 64'(out_grantId), 64'(mon_w.id));
                    check("xfer_canrx", 64'(req_canReceive), 64'(4'b0001 << mon_w.id));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        req_start      = '0;
        req_numSteps   = '0;
        req_data       = '0;
        req_isReady    = '0;
        out_canReceive = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            src_rd[i]  = 0;
            src_cnt[i] = 0;
        end

        // Reset with all requests held, then grant order 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) set_steps(i, 1);
        load(0, 64'h100); load(0, 64'h101);
        load(1, 64'h110); load(2, 64'h120); load(3, 64'h130);
        req_start = 4'b1111;
        exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
        exp_grant.push_back(3); exp_grant.push_back(0);
        push_word(64'h100, 1'b1, 0); push_word(64'h110, 1'b1, 1);
        push_word(64'h120, 1'b1, 2); push_word(64'h130, 1'b1, 3);
        push_word(64'h101, 1'b1, 0);
        for (int r = 0; r < 3; r++) begin
            step();
            @(negedge clk);
            check("rst_grant", 64'(req_grant), 64'h0);
            check("rst_isready", 64'(out_isReady), 64'h0);
            check("rst_busy", 64'(busy), 64'h0);
            check("rst_outdata", out_data, 64'h0);
        end
        step();
        rst = 1'b1;
        wait_grants(1, 20);
        #2;
        req_start[0] = 1'b1;
        drain("wrap", 80);

        // Three-word burst from requester 2, sink always ready
        xfer_cyc.delete();
        set_steps(2, 3);
        load(2, 64'hA); load(2, 64'hB); load(2, 64'hC);
        exp_grant.push_back(2);
        push_word(64'hA, 1'b0, 2); push_word(64'hB, 1'b0, 2); push_word(64'hC, 1'b1, 2);
        req_start[2] = 1'b1;
        drain("burst3", 40);
        check("burst3_count", 64'(xfer_cyc.size()), 64'd3);
        if (xfer_cyc.size() == 3) begin
            check("burst3_gap01", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd1);
            check("burst3_gap12", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd1);
        end
        check("burst3_busy_after", 64'(busy), 64'h0);

        // Backpressure on a 2-word burst from requester 3
        xfer_cyc.delete();
        set_steps(3, 2);
        load(3, 64'h40); load(3, 64'h41);
        exp_grant.push_back(3);
        push_word(64'h40, 1'b0, 3); push_word(64'h41, 1'b1, 3);
        req_start[3] = 1'b1;
        step();
        out_canReceive = 1'b1;
        step();
        out_canReceive = 1'b0;
        @(negedge clk);
        check("bp_hold_ready", 64'(out_isReady), 64'h1);
        check("bp_hold_data", out_data, 64'h41);
        check("bp_hold_canrx", 64'(req_canReceive), 64'h0);
        check("bp_hold_busy", 64'(busy), 64'h1);
        step();
        out_canReceive = 1'b1;
        step();
        out_canReceive = 1'b0;
        step();
        out_canReceive = 1'b1;
        drain("bp", 40);
        check("bp_count", 64'(xfer_cyc.size()), 64'd2);

        // Zero-length grant on requester 1, then 0,1,2 together: order 2,0,1
        set_steps(1, 0);
        exp_grant.push_back(1);
        req_start[1] = 1'b1;
        step();
        @(negedge clk);
        check("zero_busy", 64'(busy), 64'h0);
        check("zero_isready", 64'(out_isReady), 64'h0);
        step();
        set_steps(0, 1); set_steps(1, 1); set_steps(2, 1);
        load(0, 64'h200); load(1, 64'h210); load(2, 64'h220);
        exp_grant.push_back(2); exp_grant.push_back(0); exp_grant.push_back(1);
        push_word(64'h220, 1'b1, 2); push_word(64'h200, 1'b1, 0); push_word(64'h210, 1'b1, 1);
        req_start = req_start | 4'b0111;
        drain("zero_next", 60);

        // Back-to-back bursts from requesters 0 and 1, two words each
        xfer_cyc.delete();
        set_steps(0, 2); set_steps(1, 2);
        load(0, 64'h300); load(0, 64'h301); load(1, 64'h310); load(1, 64'h311);
        exp_grant.push_back(0); exp_grant.push_back(1);
        push_word(64'h300, 1'b0, 0); push_word(64'h301, 1'b1, 0);
        push_word(64'h310, 1'b0, 1); push_word(64'h311, 1'b1, 1);
        req_start = req_start | 4'b0011;
        drain("b2b", 60);
        check("b2b_count", 64'(xfer_cyc.size()), 64'd4);
        if (xfer_cyc.size() == 4) begin
`ifdef BUS_ARB_BACK2BACK_EN
            check("b2b_gap", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd1);
            check("b2b_span", 64'(xfer_cyc[3] - xfer_cyc[0]), 64'd3);
`else
            check("b2b_gap", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd2);
            check("b2b_span", 64'(xfer_cyc[3] - xfer_cyc[0]), 64'd4);
`endif
        end

        repeat (3) step();
        check("end_grant_q", 64'(exp_grant.size()), 64'd0);
        check("end_word_q", 64'(exp_word.size()), 64'd0);
        check("end_busy", 64'(busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
